// File: rtl/cla_pkg.sv
// Shared constants, types and helpers for the pipelined CLA adder.
// Exports GRP, nibble/control types and the group P/G function.
package cla_pkg;

  localparam int GRP = 4;

  typedef logic [GRP-1:0] nib_t;

  typedef struct packed {
    logic valid;
    logic carry;
    logic ovf;
  } ctl_t;

  // Returns {G, P} for one 4-bit group.
  function automatic logic [1:0] grp_pg(input nib_t a, input nib_t b);
    nib_t g;
    nib_t p;
    logic gg;
    logic pp;
    g  = a & b;
    p  = a ^ b;
    pp = &p;
    gg = g[3]
       | (p[3] & g[2])
       | (p[3] & p[2] & g[1])
       | (p[3] & p[2] & p[1] & g[0]);
    return {gg, pp};
  endfunction

endpackage

// File: rtl/cla_group4.sv
// Combinational 4-bit carry-lookahead group.
// Ports: a, b, cin in; s, p (group propagate), g (group generate), cout out.
module cla_group4
  import cla_pkg::*;
(
  input  nib_t a,
  input  nib_t b,
  input  logic cin,
  output nib_t s,
  output logic p,
  output logic g,
  output logic cout
);

  nib_t gi;
  nib_t pi;
  logic [GRP:0] c;

  assign gi = a & b;
  assign pi = a ^ b;

  assign c[0] = cin;
  assign c[1] = gi[0] | (pi[0] & cin);
  assign c[2] = gi[1] | (pi[1] & gi[0])
              | (pi[1] & pi[0] & cin);
  assign c[3] = gi[2] | (pi[2] & gi[1])
              | (pi[2] & pi[1] & gi[0])
              | (pi[2] & pi[1] & pi[0] & cin);
  assign c[4] = gi[3] | (pi[3] & gi[2])
              | (pi[3] & pi[2] & gi[1])
              | (pi[3] & pi[2] & pi[1] & gi[0])
              | (pi[3] & pi[2] & pi[1] & pi[0] & cin);

  assign s      = pi ^ c[GRP-1:0];
  assign {g, p} = grp_pg(a, b);
  assign cout   = c[GRP];

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined CLA adder/subtractor, one WIDTH/STAGES slice per stage,
// valid/ready stream in (a, b, c_in, op_sub) and out (s, c_out, ovf).
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             ovf
);

  localparam int SW  = WIDTH / STAGES;
  localparam int GPS = SW / GRP;

  // Operands skew forward, finished sum slices deskew forward.
  typedef struct packed {
    ctl_t             ctl;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] s;
  } stage_t;

  stage_t pipe [STAGES];
  logic   en;

  assign en       = !pipe[STAGES-1].ctl.valid || out_ready;
  assign in_ready = en;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    stage_t         src;
    stage_t         nxt;
    logic [GPS:0]   c;
    logic [GPS-1:0] gp;
    logic [GPS-1:0] gg;
    logic [GPS-1:0] gco;
    logic [SW-1:0]  sum;
    logic           unused_co;

    if (k == 0) begin : g_in
      always_comb begin
        src           = '0;
        src.ctl.valid = in_valid;
        src.ctl.carry = c_in;
        src.a         = a;
        src.b         = op_sub ? ~b : b;
      end
    end else begin : g_mid
      assign src = pipe[k-1];
    end

    for (genvar j = 0; j < GPS; j++) begin : g_grp
      cla_group4 u_grp (
        .a    (src.a[k*SW+j*GRP +: GRP]),
        .b    (src.b[k*SW+j*GRP +: GRP]),
        .cin  (c[j]),
        .s    (sum[j*GRP +: GRP]),
        .p    (gp[j]),
        .g    (gg[j]),
        .cout (gco[j])
      );
    end

    // Slice carries in flat sum-of-products form, no ripple.
    always_comb begin
      logic acc;
      logic t;
      acc  = 1'b0;
      t    = 1'b0;
      c    = '0;
      c[0] = src.ctl.carry;
      for (int j = 1; j <= GPS; j++) begin
        acc = src.ctl.carry;
        for (int i = 0; i < j; i++)
          acc = acc & gp[i];
        for (int i = 0; i < j; i++) begin
          t = gg[i];
          for (int m = i + 1; m < j; m++)
            t = t & gp[m];
          acc = acc | t;
        end
        c[j] = acc;
      end
    end

    // Group couts duplicate the lookahead carries.
    assign unused_co = ^gco;

    always_comb begin
      nxt                = src;
      nxt.s[k*SW +: SW]  = sum;
      nxt.ctl.carry      = c[GPS];
      nxt.ctl.ovf        = 1'b0;
      if (k == STAGES - 1)
        nxt.ctl.ovf = (src.a[WIDTH-1] == src.b[WIDTH-1])
                   && (sum[SW-1] != src.a[WIDTH-1]);
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        pipe[k] <= '0;
      else if (en)
        pipe[k] <= nxt;
    end
  end

  assign out_valid = pipe[STAGES-1].ctl.valid;
  assign s     = out_valid ? pipe[STAGES-1].s : '0;
  assign c_out = out_valid & pipe[STAGES-1].ctl.carry;
  assign ovf   = out_valid & pipe[STAGES-1].ctl.ovf;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Bench for cla_pipe_adder: 16-bit/4-stage directed, stream, stall and
// reset cases, plus a 64-bit/2-stage random run against a model.
module tb_cla_pipe_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic        rst16, iv16, or16, cin16, sub16;
  logic [15:0] a16, b16;
  logic        ir16, ov16, co16, of16;
  logic [15:0] s16;

  logic        rst64, iv64, or64, cin64, sub64;
  logic [63:0] a64, b64;
  logic        ir64, ov64, co64, of64;
  logic [63:0] s64;

  cla_pipe_adder #(.WIDTH(16), .STAGES(4)) dut16 (
    .clk(clk), .rst(rst16), .in_valid(iv16), .in_ready(ir16),
    .a(a16), .b(b16), .c_in(cin16), .op_sub(sub16),
    .out_valid(ov16), .out_ready(or16),
    .s(s16), .c_out(co16), .ovf(of16)
  );

  cla_pipe_adder #(.WIDTH(64), .STAGES(2)) dut64 (
    .clk(clk), .rst(rst64), .in_valid(iv64), .in_ready(ir64),
    .a(a64), .b(b64), .c_in(cin64), .op_sub(sub64),
    .out_valid(ov64), .out_ready(or64),
    .s(s64), .c_out(co64), .ovf(of64)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: {ovf, c_out, s} from plain arithmetic on w bits.
  function automatic logic [65:0] model(input int w,
      input logic [63:0] a, input logic [63:0] b,
      input logic cin, input logic sub);
    logic [64:0] sum;
    logic [63:0] mask, be, sm;
    logic        c, o;
    mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    be   = (sub ? ~b : b) & mask;
    sum  = {1'b0, a & mask} + {1'b0, be} + {64'd0, cin};
    c    = sum[w];
    sm   = sum[63:0] & mask;
    o    = (a[w-1] == be[w-1]) && (sm[w-1] != a[w-1]);
    return {o, c, sm};
  endfunction

  function automatic logic [63:0] pick64();
    int r;
    r = $urandom_range(0, 7);
    case (r)
      0:       return 64'h0;
      1:       return 64'hffff_ffff_ffff_ffff;
      2:       return 64'h8000_0000_0000_0000;
      3:       return 64'h7fff_ffff_ffff_ffff;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  logic [65:0] q16[$];
  logic [65:0] q64[$];
  int          acc64 = 0;

  always @(negedge clk) begin
    if (rst16) begin
      q16.delete();
    end else begin
      if (ov16) begin
        if (q16.size() == 0) begin
          chk("extra16", {63'd0, ov16}, 64'd0);
        end else begin
          chk("s16", {48'd0, s16}, {48'd0, q16[0][15:0]});
          chk("cout16", {63'd0, co16}, {63'd0, q16[0][64]});
          chk("ovf16", {63'd0, of16}, {63'd0, q16[0][65]});
          if (or16) void'(q16.pop_front());
        end
      end else begin
        chk("idle16", {46'd0, s16, co16, of16}, 64'd0);
      end
      if (iv16 && ir16)
        q16.push_back(model(16, {48'd0, a16}, {48'd0, b16}, cin16, sub16));
    end
  end

  always @(negedge clk) begin
    if (rst64) begin
      q64.delete();
    end else begin
      if (ov64) begin
        if (q64.size() == 0) begin
          chk("extra64", {63'd0, ov64}, 64'd0);
        end else begin
          chk("s64", s64, q64[0][63:0]);
          chk("cout64", {63'd0, co64}, {63'd0, q64[0][64]});
          chk("ovf64", {63'd0, of64}, {63'd0, q64[0][65]});
          if (or64) void'(q64.pop_front());
        end
      end else begin
        chk("idle64", s64 | {62'd0, co64, of64}, 64'd0);
      end
      if (iv64 && ir64) begin
        q64.push_back(model(64, a64, b64, cin64, sub64));
        acc64++;
      end
    end
  end

  task automatic op16(input logic [15:0] a, input logic [15:0] b,
                      input logic ci, input logic sb,
                      input logic [15:0] es, input logic ec,
                      input logic eo, input string nm);
    int n;
    @(posedge clk); #1;
    a16 = a; b16 = b; cin16 = ci; sub16 = sb;
    iv16 = 1'b1; or16 = 1'b1;
    @(posedge clk); #1;
    iv16 = 1'b0;
    n = 1;
    while (!ov16 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_lat"}, 64'(n), 64'd4);
    chk({nm, "_s"}, {48'd0, s16}, {48'd0, es});
    chk({nm, "_c"}, {63'd0, co16}, {63'd0, ec});
    chk({nm, "_o"}, {63'd0, of16}, {63'd0, eo});
  endtask

  task automatic rnd16();
    a16   = 16'($urandom);
    b16   = 16'($urandom);
    cin16 = 1'($urandom);
    sub16 = 1'($urandom);
  endtask

  initial begin
    int first, last, cnt, cyc;
    logic [15:0] hold;
    rst16 = 1'b1; rst64 = 1'b1;
    iv16 = 1'b0; or16 = 1'b1; a16 = '0; b16 = '0;
    cin16 = 1'b0; sub16 = 1'b0;
    iv64 = 1'b0; or64 = 1'b1; a64 = '0; b64 = '0;
    cin64 = 1'b0; sub64 = 1'b0;
    #3;
    chk("rst_ov16", {63'd0, ov16}, 64'd0);
    chk("rst_s16", {48'd0, s16}, 64'd0);
    chk("rst_ov64", {63'd0, ov64}, 64'd0);
    #19;
    rst16 = 1'b0; rst64 = 1'b0;
    @(posedge clk); #1;
    chk("ready16", {63'd0, ir16}, 64'd1);
    chk("ready64", {63'd0, ir64}, 64'd1);

    op16(16'd32445, 16'd16785, 1'b0, 1'b0, 16'd49230, 1'b0, 1'b1, "add_ovf");
    op16(16'd25021, 16'd40535, 1'b1, 1'b0, 16'd21, 1'b1, 1'b0, "add_co");
    op16(16'd12500, 16'd40535, 1'b1, 1'b0, 16'd53036, 1'b0, 1'b0, "add_nc");
    op16(16'd25020, 16'd1535, 1'b1, 1'b1, 16'd23485, 1'b1, 1'b0, "sub_pos");
    op16(16'd1535, 16'd25020, 1'b1, 1'b1, 16'd42051, 1'b0, 1'b0, "sub_neg");

    // 8 back-to-back ops must emerge on 8 consecutive cycles.
    first = -1; last = -1; cnt = 0;
    @(posedge clk); #1;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          iv16 = 1'b1;
          rnd16();
          @(posedge clk); #1;
        end
        iv16 = 1'b0;
      end
      begin
        for (int c = 0; c < 16; c++) begin
          @(posedge clk); #1;
          if (ov16) begin
            if (first < 0) first = c;
            last = c;
            cnt++;
          end
        end
      end
    join
    chk("stream_cnt", 64'(cnt), 64'd8);
    chk("stream_span", 64'(last - first), 64'd7);

    // Stall for 3 cycles mid-stream.
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          iv16 = 1'b1;
          rnd16();
          @(posedge clk); #1;
        end
        iv16 = 1'b0;
      end
      begin
        cyc = 0;
        while (!ov16 && cyc < 20) begin
          @(posedge clk); #1;
          cyc++;
        end
        chk("stall_reach", {63'd0, ov16}, 64'd1);
        or16 = 1'b0;
        hold = s16;
        for (int i = 0; i < 3; i++) begin
          #2;
          chk("stall_rdy", {63'd0, ir16}, 64'd0);
          chk("stall_s", {48'd0, s16}, {48'd0, hold});
          @(posedge clk); #1;
        end
        or16 = 1'b1;
      end
    join
    repeat (12) @(posedge clk);
    #1;
    chk("drain16", 64'(q16.size()), 64'd0);

    // Reset with ops in flight.
    for (int i = 0; i < 4; i++) begin
      iv16 = 1'b1;
      rnd16();
      @(posedge clk); #1;
    end
    iv16 = 1'b0;
    #2;
    rst16 = 1'b1;
    #1;
    chk("mrst_ov", {63'd0, ov16}, 64'd0);
    chk("mrst_s", {48'd0, s16}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst16 = 1'b0;
    @(posedge clk); #1;
    chk("mrst_rdy", {63'd0, ir16}, 64'd1);
    op16(16'd25020, 16'd1535, 1'b1, 1'b1, 16'd23485, 1'b1, 1'b0, "post_rst");
    repeat (8) @(posedge clk);
    #1;
    chk("drain16b", 64'(q16.size()), 64'd0);

    // Wide random run with random backpressure.
    cyc = 0;
    while (acc64 < 10000 && cyc < 60000) begin
      @(posedge clk); #1;
      iv64  = ($urandom % 5) != 0;
      or64  = ($urandom % 4) != 0;
      a64   = pick64();
      b64   = pick64();
      cin64 = 1'($urandom);
      sub64 = 1'($urandom);
      cyc++;
    end
    chk("budget64", {63'd0, acc64 >= 10000}, 64'd1);
    iv64 = 1'b0;
    or64 = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("drain64", 64'(q64.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
